// File: rtl/nes_cpu_bus_pkg.sv
// Shared encodings, widths and default addresses for the CPU bus arbiter slice.
package nes_cpu_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OWN_W  = 2;

  localparam logic [ADDR_W-1:0] DEF_DMA_TRIG_ADDR = 16'h4014;
  localparam logic [ADDR_W-1:0] DEF_OAM_DATA_ADDR = 16'h2004;

  // Bus owner encoding, as seen on the owner port.
  typedef enum logic [OWN_W-1:0] {
    OWN_IE  = 2'd0,
    OWN_IH  = 2'd1,
    OWN_DMA = 2'd2
  } owner_e;

  // OAM DMA sequencer states.
  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_HALT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_READ  = 3'd3,
    DMA_WRITE = 3'd4,
    DMA_DONE  = 3'd5
  } dma_state_e;

  // One master's request onto the shared bus.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
  } bus_req_t;

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: copies page {page,00..FF} to the OAM data port, one
// read/write pair per byte, with an optional alignment dummy cycle.
module oam_dma_engine
  import nes_cpu_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_i,
  input  logic [DATA_W-1:0] page_i,
  input  logic              pause_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [ADDR_W-1:0] dma_addr_o,
  output logic [DATA_W-1:0] dma_wdata_o,
  output logic              dma_we_o,
  output logic              dma_busy_o,
  output logic              dma_done_o
);

  dma_state_e        state_q;
  logic [DATA_W-1:0] page_q;
  logic [DATA_W-1:0] idx_q;
  logic [DATA_W-1:0] idx_d;
  logic [DATA_W-1:0] dbuf_q;
  logic              parity_q;
  logic              align_q;
  logic              busy_q;
  logic              done_q;

  assign idx_d      = idx_q + 8'd1;
  assign dma_busy_o = busy_q;
  assign dma_done_o = done_q;

  // Sequencer, data path registers and free-running parity; pause freezes
  // everything except parity. The align decision is keyed to the parity of
  // the triggering write cycle and carried through HALT in align_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DMA_IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      dbuf_q   <= '0;
      parity_q <= 1'b0;
      align_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
      done_q   <= 1'b0;
      if (!pause_i) begin
        case (state_q)
          DMA_IDLE: begin
            if (trig_i) begin
              page_q  <= page_i;
              align_q <= parity_q;
              busy_q  <= 1'b1;
              state_q <= DMA_HALT;
            end
          end
          DMA_HALT:  state_q <= align_q ? DMA_ALIGN : DMA_READ;
          DMA_ALIGN: state_q <= DMA_READ;
          DMA_READ: begin
            dbuf_q  <= rdata_i;
            state_q <= DMA_WRITE;
          end
          DMA_WRITE: begin
            idx_q <= idx_d;
            if (idx_q == 8'hFF) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DMA_DONE;
            end else begin
              state_q <= DMA_READ;
            end
          end
          DMA_DONE: begin
            idx_q   <= '0;
            state_q <= DMA_IDLE;
          end
          default: state_q <= DMA_IDLE;
        endcase
      end
    end
  end

  // Bus request decoded from state; dummy cycles present a quiet bus.
  always_comb begin
    dma_addr_o  = '0;
    dma_wdata_o = '0;
    dma_we_o    = 1'b0;
    case (state_q)
      DMA_READ:  dma_addr_o = ADDR_W'({page_q, idx_q});
      DMA_WRITE: begin
        dma_addr_o  = OAM_DATA_ADDR;
        dma_wdata_o = dbuf_q;
        dma_we_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// CPU-side bus arbiter: DMA > IH > IE ownership, zero-latency bus mux,
// halt generation and OAM DMA trigger decode.
module cpu_bus_arbiter
  import nes_cpu_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DMA_TRIG_ADDR = DEF_DMA_TRIG_ADDR,
  parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ie_addr_i,
  input  logic [DATA_W-1:0] ie_wdata_i,
  input  logic              ie_we_i,
  input  logic              ih_active_i,
  input  logic [ADDR_W-1:0] ih_addr_i,
  input  logic [DATA_W-1:0] ih_wdata_i,
  input  logic              ih_we_i,
  input  logic              halt_in_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  output logic [OWN_W-1:0]  owner_o,
  output logic              halt_o,
  output logic              dma_busy_o,
  output logic              dma_done_o
);

  bus_req_t          ie_req;
  bus_req_t          ih_req;
  bus_req_t          dma_req;
  bus_req_t          sel_req;
  owner_e            owner_c;
  logic              trig_c;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_we;

  assign ie_req  = '{addr: ie_addr_i, wdata: ie_wdata_i, we: ie_we_i};
  assign ih_req  = '{addr: ih_addr_i, wdata: ih_wdata_i, we: ih_we_i};
  assign dma_req = '{addr: dma_addr, wdata: dma_wdata, we: dma_we};

  // Only an unhalted IE write to the trigger address while IE owns the bus starts DMA.
  assign trig_c = (owner_c == OWN_IE) && ie_we_i && (ie_addr_i == DMA_TRIG_ADDR) && !halt_in_i;

  oam_dma_engine #(
    .OAM_DATA_ADDR(OAM_DATA_ADDR)
  ) u_dma (
    .clk        (clk),
    .rst        (rst),
    .trig_i     (trig_c),
    .page_i     (ie_wdata_i),
    .pause_i    (halt_in_i),
    .rdata_i    (mem_rdata_i),
    .dma_addr_o (dma_addr),
    .dma_wdata_o(dma_wdata),
    .dma_we_o   (dma_we),
    .dma_busy_o (dma_busy_o),
    .dma_done_o (dma_done_o)
  );

  // Ownership priority and bus select.
  always_comb begin
    owner_c = OWN_IE;
    sel_req = ie_req;
    if (dma_busy_o) begin
      owner_c = OWN_DMA;
      sel_req = dma_req;
    end else if (ih_active_i) begin
      owner_c = OWN_IH;
      sel_req = ih_req;
    end
  end

  assign owner_o     = owner_c;
  assign mem_addr_o  = sel_req.addr;
  assign mem_wdata_o = sel_req.wdata;
  assign mem_we_o    = sel_req.we & ~halt_in_i;
  assign halt_o      = halt_in_i | dma_busy_o;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter with a scoreboard on DMA bus traffic.
module tb_cpu_bus_arbiter;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] OAM  = 16'h2004;

  logic        clk;
  logic        rst;
  logic [15:0] ie_addr;
  logic [7:0]  ie_wdata;
  logic        ie_we;
  logic        ih_active;
  logic [15:0] ih_addr;
  logic [7:0]  ih_wdata;
  logic        ih_we;
  logic        halt_in;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_we_o;
  logic [1:0]  owner_o;
  logic        halt_o;
  logic        dma_busy_o;
  logic        dma_done_o;

  int total, bad;
  int halt_cnt, done_cnt, dummy_cnt, wr_cnt, rd_cnt, wr2004;
  bit done_seen;
  logic tb_par;
  logic [24:0] exp_q[$];

  cpu_bus_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .ie_addr_i  (ie_addr),
    .ie_wdata_i (ie_wdata),
    .ie_we_i    (ie_we),
    .ih_active_i(ih_active),
    .ih_addr_i  (ih_addr),
    .ih_wdata_i (ih_wdata),
    .ih_we_i    (ih_we),
    .halt_in_i  (halt_in),
    .mem_rdata_i(mem_rdata),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_we_o   (mem_we_o),
    .owner_o    (owner_o),
    .halt_o     (halt_o),
    .dma_busy_o (dma_busy_o),
    .dma_done_o (dma_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple RAM model answering in the same cycle.
  function automatic logic [7:0] ram_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction
  assign mem_rdata = ram_byte(mem_addr_o);

  // Reference parity: cleared by reset, toggles every clock.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_par <= 1'b0;
    else      tb_par <= ~tb_par;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard for each DMA bus beat and keeps counters.
  always @(negedge clk) begin
    logic [24:0] ev;
    logic [24:0] e;
    if (rst) begin
      if (halt_o) halt_cnt++;
      if (dma_done_o) begin
        done_cnt++;
        done_seen = 1'b1;
      end
      if (mem_we_o && mem_addr_o == OAM) wr2004++;
      if (halt_in && dma_busy_o) check("pause_we", 32'(mem_we_o), 32'd0);
      if (owner_o == 2'd2 && !halt_in) begin
        if (!mem_we_o && mem_addr_o == 16'h0000) begin
          dummy_cnt++;
        end else begin
          ev = {mem_we_o, mem_addr_o, (mem_we_o ? mem_wdata_o : 8'h00)};
          if (mem_we_o) wr_cnt++;
          else          rd_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got %0h expected none", ev);
          end else begin
            e = exp_q.pop_front();
            check("sb_bus", 32'(ev), 32'(e));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One OAM DMA run from trigger to completion (or to a reset at idx 0x80).
  task automatic run_dma(input logic [7:0] pg, input logic par, input bit do_ignore,
                         input bit do_pause, input bit do_rst, input int exp_halt,
                         input int exp_dummy, input string tag);
    int cyc;
    bit paused;
    cyc = 0;
    while (tb_par !== par && cyc < 4) begin
      step();
      cyc++;
    end
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({1'b0, pg, 8'(i), 8'h00});
      exp_q.push_back({1'b1, OAM, ram_byte({pg, 8'(i)})});
    end
    halt_cnt = 0; done_cnt = 0; dummy_cnt = 0; wr_cnt = 0; rd_cnt = 0;
    done_seen = 1'b0;
    ie_addr = TRIG; ie_wdata = pg; ie_we = 1'b1;
    #1;
    check({tag, "_trig_owner"}, 32'(owner_o), 32'd0);
    check({tag, "_trig_we"}, 32'(mem_we_o), 32'd1);
    check({tag, "_trig_addr"}, 32'(mem_addr_o), 32'(TRIG));
    step();
    ie_we = 1'b0; ie_addr = 16'h8000;
    #1;
    check({tag, "_halt_rise"}, 32'(halt_o), 32'd1);
    check({tag, "_owner_dma"}, 32'(owner_o), 32'd2);
    if (do_ignore) begin
      ie_addr = TRIG; ie_wdata = 8'h55; ie_we = 1'b1;
      ih_active = 1'b1; ih_addr = TRIG; ih_wdata = 8'h66; ih_we = 1'b1;
      repeat (3) begin
        step();
        check({tag, "_ih_blocked"}, 32'(owner_o), 32'd2);
      end
      ie_we = 1'b0; ie_addr = 16'h8000; ih_active = 1'b0; ih_we = 1'b0;
    end
    cyc = 0;
    paused = 1'b0;
    while (!done_seen && cyc < 2000) begin
      if (do_pause && !paused && wr_cnt == 64) begin
        check({tag, "_pause_idx"}, 32'(mem_addr_o), 32'({pg, 8'h40}));
        halt_in = 1'b1;
        repeat (10) step();
        halt_in = 1'b0;
        paused = 1'b1;
      end
      if (do_rst && wr_cnt == 128) begin
        check({tag, "_rst_idx"}, 32'(mem_addr_o), 32'({pg, 8'h80}));
        rst = 1'b0;
        #1;
        check({tag, "_rst_busy"}, 32'(dma_busy_o), 32'd0);
        check({tag, "_rst_owner"}, 32'(owner_o), 32'd0);
        check({tag, "_rst_halt0"}, 32'(halt_o), 32'd0);
        halt_in = 1'b1;
        #1;
        check({tag, "_rst_halt1"}, 32'(halt_o), 32'd1);
        halt_in = 1'b0;
        exp_q.delete();
        step();
        step();
        rst = 1'b1;
        wr2004 = 0;
        repeat (600) step();
        check({tag, "_no_writes"}, 32'(wr2004), 32'd0);
        check({tag, "_idle_busy"}, 32'(dma_busy_o), 32'd0);
        check({tag, "_no_done"}, 32'(done_cnt), 32'd0);
        return;
      end
      step();
      cyc++;
    end
    check({tag, "_completed"}, 32'(done_seen), 32'd1);
    repeat (3) step();
    check({tag, "_halt_cycles"}, 32'(halt_cnt), 32'(exp_halt));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_dummy_cycles"}, 32'(dummy_cnt), 32'(exp_dummy));
    check({tag, "_reads"}, 32'(rd_cnt), 32'd256);
    check({tag, "_writes"}, 32'(wr_cnt), 32'd256);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_low"}, 32'(dma_busy_o), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    halt_cnt = 0; done_cnt = 0; dummy_cnt = 0; wr_cnt = 0; rd_cnt = 0; wr2004 = 0;
    done_seen = 1'b0;
    rst = 1'b0;
    ie_addr = 16'h8000; ie_wdata = 8'h00; ie_we = 1'b1;
    ih_active = 1'b0; ih_addr = 16'h0000; ih_wdata = 8'h00; ih_we = 1'b0;
    halt_in = 1'b1;

    // Reset state.
    #3;
    check("rst_owner", 32'(owner_o), 32'd0);
    check("rst_halt_follows", 32'(halt_o), 32'd1);
    check("rst_busy", 32'(dma_busy_o), 32'd0);
    check("rst_done", 32'(dma_done_o), 32'd0);
    check("rst_we_gated", 32'(mem_we_o), 32'd0);
    halt_in = 1'b0; ie_we = 1'b0;
    #1;
    check("rst_halt_low", 32'(halt_o), 32'd0);
    step();
    rst = 1'b1;
    step();

    // Idle ownership.
    check("idle_owner", 32'(owner_o), 32'd0);
    check("idle_addr", 32'(mem_addr_o), 32'h8000);
    check("idle_halt", 32'(halt_o), 32'd0);

    // IH takeover, same cycle, then halt gating of its write.
    ih_active = 1'b1; ih_addr = 16'h01FD; ih_we = 1'b1; ih_wdata = 8'hC0;
    #1;
    check("ih_owner", 32'(owner_o), 32'd1);
    check("ih_addr", 32'(mem_addr_o), 32'h01FD);
    check("ih_wdata", 32'(mem_wdata_o), 32'hC0);
    check("ih_we", 32'(mem_we_o), 32'd1);
    halt_in = 1'b1;
    #1;
    check("halt_gate_we", 32'(mem_we_o), 32'd0);
    check("halt_gate_halt", 32'(halt_o), 32'd1);
    halt_in = 1'b0;

    // IH write to the trigger address does not start DMA.
    ih_addr = TRIG; ih_wdata = 8'h02;
    step();
    ih_active = 1'b0; ih_we = 1'b0;
    #1;
    check("ih_trig_ignored", 32'(dma_busy_o), 32'd0);

    // IE trigger while externally halted does not start DMA.
    ie_addr = TRIG; ie_wdata = 8'h02; ie_we = 1'b1; halt_in = 1'b1;
    step();
    ie_we = 1'b0; ie_addr = 16'h8000; halt_in = 1'b0;
    #1;
    check("halted_trig_ignored", 32'(dma_busy_o), 32'd0);
    step();

    run_dma(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 513, 1, "even");
    run_dma(8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 514, 2, "odd");
    run_dma(8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 523, 1, "pause");
    run_dma(8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, "reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
